// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants, the dout
// source select used by the top level, and a constant-foldable clog2.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  typedef enum logic [1:0] {
    DOUT_ZERO,
    DOUT_MEM,
    DOUT_BYPASS
  } dout_sel_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array with registered read; contents are never
// reset, so it maps onto block RAM.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_array[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_array[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy flags, programmable almost
// thresholds, overflow/underflow pulses and optional first-word-fall-through.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_STD,
  localparam int PTR_SIZE  = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_SIZE-1:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = PTR_SIZE - 1;

  logic [PTR_SIZE-1:0]   wr_ptr_reg, rd_ptr_reg, count_reg;
  logic [PTR_SIZE-1:0]   wr_ptr_next, rd_ptr_next, count_next;
  logic                  full_reg, empty_reg, af_reg, ae_reg, ovf_reg, udf_reg;
  logic                  full_next, empty_next;
  logic                  wr_accept, rd_accept, bypass_hit, mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data, bypass_reg;
  dout_sel_t             sel_reg, sel_next;

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (din),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    wr_accept   = wr_en && !full_reg;
    rd_accept   = rd_en && !empty_reg;
    wr_ptr_next = wr_ptr_reg + PTR_SIZE'(wr_accept);
    rd_ptr_next = rd_ptr_reg + PTR_SIZE'(rd_accept);
    count_next  = count_reg + PTR_SIZE'(wr_accept) - PTR_SIZE'(rd_accept);
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    empty_next  = (wr_ptr_next == rd_ptr_next);
    bypass_hit  = 1'b0;
    sel_next    = sel_reg;
    if (FWFT == FIFO_FWFT) begin
      // Prefetch the head for the next cycle; a word written into the slot
      // about to become the head is not in the array yet, so forward din.
      mem_rd_en   = 1'b1;
      mem_rd_addr = rd_ptr_next[AW-1:0];
      bypass_hit  = wr_accept && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);
      if (bypass_hit)
        sel_next = DOUT_BYPASS;
      else if (sel_reg == DOUT_ZERO && empty_next)
        sel_next = DOUT_ZERO;
      else
        sel_next = DOUT_MEM;
    end else begin
      mem_rd_en   = rd_accept;
      mem_rd_addr = rd_ptr_reg[AW-1:0];
      if (rd_accept) sel_next = DOUT_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
      sel_reg    <= DOUT_ZERO;
      bypass_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      af_reg     <= (count_next >= PTR_SIZE'(AF_LEVEL));
      ae_reg     <= (count_next <= PTR_SIZE'(AE_LEVEL));
      ovf_reg    <= wr_en && full_reg;
      udf_reg    <= rd_en && empty_reg;
      sel_reg    <= sel_next;
      if (bypass_hit) bypass_reg <= din;
    end
  end

  always_comb begin
    case (sel_reg)
      DOUT_MEM:    dout = mem_rd_data;
      DOUT_BYPASS: dout = bypass_reg;
      default:     dout = '0;
    endcase
  end

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: a standard-read instance (dut0) carries most scenarios,
// a first-word-fall-through instance (dut1) covers the FWFT behaviour.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en0, rd_en0, wr_en1, rd_en1;
  logic [7:0] din0, din1, dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;

  sync_fifo_flags #(.DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .din(din0), .rd_en(rd_en0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_flags #(.DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .din(din1), .rd_en(rd_en1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1));

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] sb[$];
  int         model_cnt = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovf, exp_udf;

  task automatic model_reset();
    sb.delete();
    model_cnt = 0;
    exp_dout  = 8'h00;
  endtask

  // One clock of dut0 stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic acc_w, acc_r;
    acc_w   = w && (model_cnt < 16);
    acc_r   = r && (model_cnt > 0);
    exp_ovf = w && (model_cnt == 16);
    exp_udf = r && (model_cnt == 0);
    if (acc_r) begin exp_dout = sb.pop_front(); model_cnt--; end
    if (acc_w) begin sb.push_back(d); model_cnt++; end
    wr_en0 = w; din0 = d; rd_en0 = r;
    @(posedge clk); #1;
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    $display("txn wr=%0b din=%02h rd=%0b -> count=%0d dout=%02h", w, d, r, count0, dout0);
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    compared++; if (count0 !== 5'd0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", count0); end
    compared++; if (empty0 !== 1'b1 || ae0 !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %0b/%0b expected 1/1", empty0, ae0); end
    compared++; if (full0 !== 1'b0 || af0 !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %0b/%0b expected 0/0", full0, af0); end
    compared++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %0b/%0b expected 0/0", ovf0, udf0); end
    compared++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin mismatched++; $display("FAIL reset_dout: got %02h/%02h expected 00/00", dout0, dout1); end
    compared++; if (empty1 !== 1'b1 || count1 !== 5'd0) begin mismatched++; $display("FAIL reset_fwft: got %0b/%0d expected 1/0", empty1, count1); end
    model_reset();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      compared++; if (count0 !== 5'(model_cnt)) begin mismatched++; $display("FAIL fill_count: got %0d expected %0d", count0, model_cnt); end
      compared++; if (full0 !== (model_cnt == 16)) begin mismatched++; $display("FAIL fill_full: got %0b expected %0b", full0, model_cnt == 16); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL drain_dout: got %02h expected %02h", dout0, exp_dout); end
    end
    compared++; if (empty0 !== 1'b1 || count0 !== 5'd0) begin mismatched++; $display("FAIL drain_end: got %0b/%0d expected 1/0", empty0, count0); end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0);
      compared++; if (ae0 !== (model_cnt <= 2)) begin mismatched++; $display("FAIL thr_ae: count %0d got %0b expected %0b", model_cnt, ae0, model_cnt <= 2); end
      compared++; if (af0 !== (model_cnt >= 14)) begin mismatched++; $display("FAIL thr_af: count %0d got %0b expected %0b", model_cnt, af0, model_cnt >= 14); end
    end
    step(1'b0, 8'h00, 1'b1);
    compared++; if (af0 !== 1'b0) begin mismatched++; $display("FAIL thr_af_drop: got %0b expected 0", af0); end
    while (model_cnt > 0) begin
      step(1'b0, 8'h00, 1'b1);
      compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL thr_dout: got %02h expected %02h", dout0, exp_dout); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    compared++; if (ovf0 !== exp_ovf || exp_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_pulse: got %0b expected 1", ovf0); end
    compared++; if (count0 !== 5'd16) begin mismatched++; $display("FAIL ovf_count: got %0d expected 16", count0); end
    step(1'b0, 8'h00, 1'b0);
    compared++; if (ovf0 !== 1'b0) begin mismatched++; $display("FAIL ovf_one_cycle: got %0b expected 0", ovf0); end
    while (model_cnt > 0) begin
      step(1'b0, 8'h00, 1'b1);
      compared++; if (dout0 !== exp_dout || dout0 === 8'hAA) begin mismatched++; $display("FAIL ovf_dout: got %02h expected %02h", dout0, exp_dout); end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1);
    compared++; if (udf0 !== exp_udf || exp_udf !== 1'b1) begin mismatched++; $display("FAIL udf_pulse: got %0b expected 1", udf0); end
    compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL udf_dout_hold: got %02h expected %02h", dout0, exp_dout); end
    compared++; if (count0 !== 5'd0) begin mismatched++; $display("FAIL udf_count: got %0d expected 0", count0); end
    step(1'b0, 8'h00, 1'b0);
    compared++; if (udf0 !== 1'b0) begin mismatched++; $display("FAIL udf_one_cycle: got %0b expected 0", udf0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'hD0 + i), 1'b1);
      compared++; if (count0 !== 5'd8) begin mismatched++; $display("FAIL b2b_count: got %0d expected 8", count0); end
      compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL b2b_dout: got %02h expected %02h", dout0, exp_dout); end
    end
    while (model_cnt > 0) begin
      step(1'b0, 8'h00, 1'b1);
      compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL b2b_drain: got %02h expected %02h", dout0, exp_dout); end
    end
  endtask

  task automatic test_fwft();
    logic [7:0] fq[$];
    logic [7:0] seq[4];
    seq[0] = 8'h5A; seq[1] = 8'h5B; seq[2] = 8'h5C; seq[3] = 8'h5D;
    for (int i = 0; i < 3; i++) begin
      wr_en1 = 1'b1; din1 = seq[i]; fq.push_back(seq[i]);
      @(posedge clk); #1; wr_en1 = 1'b0;
      $display("txn fwft wr din=%02h -> empty=%0b dout=%02h", seq[i], empty1, dout1);
      compared++; if (empty1 !== 1'b0 || dout1 !== fq[0]) begin mismatched++; $display("FAIL fwft_head: got %0b/%02h expected 0/%02h", empty1, dout1, fq[0]); end
    end
    rd_en1 = 1'b1; void'(fq.pop_front());
    @(posedge clk); #1; rd_en1 = 1'b0;
    $display("txn fwft rd -> dout=%02h", dout1);
    compared++; if (dout1 !== fq[0]) begin mismatched++; $display("FAIL fwft_pop: got %02h expected %02h", dout1, fq[0]); end
    wr_en1 = 1'b1; din1 = seq[3]; rd_en1 = 1'b1; fq.push_back(seq[3]); void'(fq.pop_front());
    @(posedge clk); #1; wr_en1 = 1'b0; rd_en1 = 1'b0;
    $display("txn fwft wr+rd din=%02h -> count=%0d dout=%02h", seq[3], count1, dout1);
    compared++; if (dout1 !== fq[0] || count1 !== 5'd2) begin mismatched++; $display("FAIL fwft_wr_rd: got %02h/%0d expected %02h/2", dout1, count1, fq[0]); end
    step(1'b1, 8'h77, 1'b0);
    #2; rst = 1'b1; #1;
    compared++; if (empty1 !== 1'b1 || count1 !== 5'd0) begin mismatched++; $display("FAIL fwft_rst: got %0b/%0d expected 1/0", empty1, count1); end
    compared++; if (empty0 !== 1'b1 || count0 !== 5'd0 || dout0 !== 8'h00) begin mismatched++; $display("FAIL std_rst: got %0b/%0d/%02h expected 1/0/00", empty0, count0, dout0); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    step(1'b1, 8'h11, 1'b0);
    compared++; if (count0 !== 5'd1) begin mismatched++; $display("FAIL first_write: got %0d expected 1", count0); end
    step(1'b0, 8'h00, 1'b1);
    compared++; if (dout0 !== exp_dout) begin mismatched++; $display("FAIL first_read: got %02h expected %02h", dout0, exp_dout); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; din0 = 8'h00;
    wr_en1 = 1'b0; rd_en1 = 1'b0; din1 = 8'h00;
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 The block SHALL have parameter FWFT, default 0, read mode (0 = standard registered read, 1 = first-word-fall-through).
REQ-006 The block SHALL derive local constant PTR_SIZE = clog2(DEPTH)+1, not settable by instantiation.
REQ-007 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port wr_en, input, 1, write request.
REQ-010 The block SHALL have port din, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port rd_en, input, 1, read request (FWFT: pop of presented word).
REQ-012 The block SHALL have port dout, output, DATA_WIDTH, read data.
REQ-013 The block SHALL have ports full and empty, output, 1 each, occupancy status.
REQ-014 The block SHALL have ports almost_full and almost_empty, output, 1 each, threshold status.
REQ-015 The block SHALL have port count, output, PTR_SIZE, current occupancy 0..DEPTH.
REQ-016 The block SHALL have ports overflow and underflow, output, 1 each, one-cycle error pulses.

Function
REQ-017 A write SHALL be accepted on a rising edge iff wr_en=1 and full=0; din stored at wr_ptr, wr_ptr increments.
REQ-018 A read SHALL be accepted on a rising edge iff rd_en=1 and empty=0; rd_ptr increments.
REQ-019 Pointers SHALL be PTR_SIZE bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-020 Simultaneous accepted write and read SHALL leave count unchanged; when full only the read is accepted, when empty only the write.
REQ-021 count, full, empty, almost_full, almost_empty SHALL be registered and update in the cycle following the accepting edge.
REQ-022 almost_full SHALL equal (count >= AF_LEVEL); almost_empty SHALL equal (count <= AE_LEVEL).
REQ-023 FWFT=0: dout SHALL be registered, showing the read word one cycle after the accepting edge, holding otherwise.
REQ-024 FWFT=1: dout SHALL present the head entry whenever empty=0, rd_en pops it, next entry visible after the edge; dout undefined-but-stable when empty.
REQ-025 A rejected write (wr_en=1, full=1) SHALL pulse overflow high for exactly one cycle; storage and pointers unchanged.
REQ-026 A rejected read (rd_en=1, empty=1) SHALL pulse underflow high for exactly one cycle; dout unchanged.

Reset
REQ-027 rst=1 SHALL immediately clear pointers, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
REQ-028 Reset asserted mid-transfer SHALL discard all contents; storage array need not be cleared.
REQ-029 The first accepted write SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the clog2 function and mode constants FIFO_STD=0, FIFO_FWFT=1.
REQ-031 Storage SHALL be a sub-module fifo_mem (DEPTH x DATA_WIDTH, one write port, one read port, no reset).

Verification (DEPTH=16, DATA_WIDTH=8, AF_LEVEL=14, AE_LEVEL=2)
REQ-032 Write 0..15 then read 16 (FWFT=0) -> full=1, count=16 after last write; dout 0..15 in order, each one cycle after rd_en; empty=1 at end.
REQ-033 Write 3 entries -> almost_empty deasserts when count=3; write to count 14 -> almost_full=1; read one -> almost_full=0.
REQ-034 Full FIFO, wr_en=1 with din=0xAA -> overflow one-cycle pulse, count stays 16, 0xAA never read out.
REQ-035 Empty FIFO, rd_en=1 -> underflow one-cycle pulse, dout holds previous value, count stays 0.
REQ-036 count=8, wr_en=rd_en=1 for 20 cycles with incrementing din -> count stays 8, data order preserved across pointer wrap.
REQ-037 FWFT=1: write 0x5A into empty FIFO -> dout=0x5A with empty=0 next cycle, no rd_en; rst pulse mid-stream -> empty=1, count=0 immediately.
